razor_recovery_ctrl: RTL and testbench

Pipeline-level recovery sequencer for the Razor-protected CPU. Collects the per-stage shadow-latch error flags from the IF/ID, ID/EX, EX/MEM and MEM/WB razor registers. On an error it stalls the pipeline, pulses the razor register resets, and flushes the errored stage and every younger stage. After a fixed replay window it redirects fetch to the PC of the oldest errored instruction. It also tracks recovery events and raises a slow-down request when the error rate crosses a threshold.

---
 rtl/razor_pkg.sv | 23 ++
 rtl/razor_recovery_ctrl_if.sv | 37 +++
 rtl/razor_err_prio.sv | 34 +++
 rtl/razor_recovery_ctrl.sv | 113 +++++++++++
 tb/tb_razor_recovery_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/razor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : razor_pkg
// Brief    : Shared Razor pipeline types: recovery FSM states, stage indices.
// Revision : 1.0
// ============================================================================
package razor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REPLAY   = 2'd2,
        REDIRECT = 2'd3
    } razor_state_t;

    // Razor-protected pipeline registers, youngest first
    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

endpackage
`default_nettype wire

// File: rtl/razor_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : razor_recovery_ctrl_if
// Brief    : Error/PC inputs and recovery control outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface razor_recovery_ctrl_if #(
    parameter int NSTAGES = 4,
    parameter int CNT_W   = 16
);
    logic [NSTAGES-1:0]    stage_err;
    logic [32*NSTAGES-1:0] stage_pc;
    logic                  slow_ack;
    logic                  stall;
    logic [NSTAGES-1:0]    flush;
    logic                  razor_reset;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  recovering;
    logic [CNT_W-1:0]      err_count;
    logic                  slow_req;

    // master: pipeline / clock manager side
    modport master (
        output stage_err, stage_pc, slow_ack,
        input  stall, flush, razor_reset, redirect_valid, redirect_pc,
               recovering, err_count, slow_req
    );

    // slave: recovery controller side
    modport slave (
        input  stage_err, stage_pc, slow_ack,
        output stall, flush, razor_reset, redirect_valid, redirect_pc,
               recovering, err_count, slow_req
    );
endinterface
`default_nettype wire

// File: rtl/razor_err_prio.sv
`default_nettype none
// ============================================================================
// Module   : razor_err_prio
// Brief    : Oldest-stage error encoder: index, valid, thermometer flush mask.
// Revision : 1.0
// ============================================================================
module razor_err_prio #(
    parameter int NSTAGES = 4,
    parameter int IDX_W   = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
    input  wire logic [NSTAGES-1:0] err,
    output logic      [IDX_W-1:0]   idx,
    output logic                    valid,
    output logic      [NSTAGES-1:0] mask
);

    always_comb begin
        logic w_acc;
        idx   = '0;
        valid = |err;
        mask  = '0;
        w_acc = 1'b0;
        for (int i = 0; i < NSTAGES; i++) begin
            if (err[i]) idx = IDX_W'(i);
        end
        // Each stage is flushed when it or any older stage errored
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            w_acc   = w_acc | err[i];
            mask[i] = w_acc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/razor_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : razor_recovery_ctrl
// Brief    : Razor recovery sequencer: stall, flush, replay, fetch redirect.
// Revision : 1.0
// ============================================================================
module razor_recovery_ctrl
    import razor_pkg::*;
#(
    parameter int NSTAGES       = 4,
    parameter int REPLAY_CYCLES = 2,
    parameter int ERR_THRESH    = 8,
    parameter int CNT_W         = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    razor_recovery_ctrl_if.slave  bus
);

    localparam int c_IDX_W  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam int c_RCNT_W = $clog2(REPLAY_CYCLES + 1);

    razor_state_t          r_state;
    logic [31:0]           r_pc_cap;
    logic [NSTAGES-1:0]    r_mask_cap;
    logic [c_RCNT_W-1:0]   r_rcnt;
    logic [CNT_W-1:0]      r_err_count;
    logic                  r_slow_req;

    logic [c_IDX_W-1:0]    w_err_idx;
    logic                  w_err_valid;
    logic [NSTAGES-1:0]    w_err_mask;
    logic [31:0]           w_pc_sel;
    logic                  w_cnt_inc;
    logic [CNT_W-1:0]      w_cnt_next;

    razor_err_prio #(
        .NSTAGES (NSTAGES),
        .IDX_W   (c_IDX_W)
    ) u_prio (
        .err   (bus.stage_err),
        .idx   (w_err_idx),
        .valid (w_err_valid),
        .mask  (w_err_mask)
    );

    always_comb begin
        w_pc_sel = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            if (w_err_idx == c_IDX_W'(k)) w_pc_sel = bus.stage_pc[32*k +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pc_cap   <= '0;
            r_mask_cap <= '0;
            r_rcnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_err_valid) begin
                        r_pc_cap   <= w_pc_sel;
                        r_mask_cap <= w_err_mask;
                        r_state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_rcnt  <= c_RCNT_W'(REPLAY_CYCLES);
                    r_state <= REPLAY;
                end
                REPLAY: begin
                    r_rcnt <= r_rcnt - c_RCNT_W'(1);
                    if (r_rcnt == c_RCNT_W'(1)) r_state <= REDIRECT;
                end
                REDIRECT: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    // A slow_ack coinciding with a new event leaves that event counted
    assign w_cnt_inc  = (r_state == IDLE) && w_err_valid;
    always_comb begin
        w_cnt_next = r_err_count;
        if (bus.slow_ack)
            w_cnt_next = w_cnt_inc ? CNT_W'(1) : '0;
        else if (w_cnt_inc && !(&r_err_count))
            w_cnt_next = r_err_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
            r_slow_req  <= 1'b0;
        end else begin
            r_err_count <= w_cnt_next;
            r_slow_req  <= (64'(w_cnt_next) >= 64'(ERR_THRESH));
        end
    end

    assign bus.stall          = (r_state != IDLE);
    assign bus.recovering     = (r_state != IDLE);
    assign bus.razor_reset    = (r_state == FLUSH);
    assign bus.flush          = (r_state == FLUSH) ? r_mask_cap : '0;
    assign bus.redirect_valid = (r_state == REDIRECT);
    assign bus.redirect_pc    = (r_state == REDIRECT) ? r_pc_cap : 32'h0;
    assign bus.err_count      = r_err_count;
    assign bus.slow_req       = r_slow_req;

endmodule
`default_nettype wire

// File: tb/tb_razor_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_razor_recovery_ctrl
// Brief    : Scoreboard bench for razor_recovery_ctrl with directed recoveries.
// Revision : 1.0
// ============================================================================
module tb_razor_recovery_ctrl;

    localparam int c_NST    = 4;
    localparam int c_REPLAY = 2;
    localparam int c_THRESH = 8;
    localparam int c_CNT_W  = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    razor_recovery_ctrl_if #(.NSTAGES(c_NST), .CNT_W(c_CNT_W)) bus ();

    razor_recovery_ctrl #(
        .NSTAGES       (c_NST),
        .REPLAY_CYCLES (c_REPLAY),
        .ERR_THRESH    (c_THRESH),
        .CNT_W         (c_CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        slow;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_cnt = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    function automatic logic [127:0] pcs4(input logic [31:0] p3, input logic [31:0] p2,
                                          input logic [31:0] p1, input logic [31:0] p0);
        return {p3, p2, p1, p0};
    endfunction

    // Monitor: pops one expected recovery at each FLUSH and tracks it to REDIRECT
    exp_t cur;
    logic active         = 1'b0;
    int   wait_cnt       = 0;
    int   stall_run      = 0;
    int   last_flush_cyc = 0;
    int   prev_flush_cyc = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            active    = 1'b0;
            stall_run = 0;
        end else begin
            if (bus.stall) stall_run++;
            else if (stall_run > 0) begin
                check("stall_len", stall_run, c_REPLAY + 2);
                stall_run = 0;
            end
            if (bus.razor_reset) begin
                prev_flush_cyc = last_flush_cyc;
                last_flush_cyc = cyc;
                if (active) fail_evt("overlapping_flush");
                if (exp_q.size() == 0) fail_evt("unexpected_flush");
                else begin
                    cur = exp_q.pop_front();
                    check("flush_mask", bus.flush, cur.mask);
                    check("flush_cnt", bus.err_count, cur.cnt);
                    check("flush_slow", bus.slow_req, cur.slow);
                    active   = 1'b1;
                    wait_cnt = 0;
                end
            end else if (active) begin
                wait_cnt++;
                if (bus.redirect_valid) begin
                    check("redirect_lat", wait_cnt, c_REPLAY + 1);
                    check("redirect_pc", bus.redirect_pc, cur.pc);
                    check("redirect_cnt", bus.err_count, cur.cnt);
                    active = 1'b0;
                end else begin
                    check("replay_flush", bus.flush, 0);
                    if (wait_cnt > c_REPLAY + 1) begin
                        fail_evt("redirect_timeout");
                        active = 1'b0;
                    end
                end
            end else if (bus.redirect_valid) fail_evt("unexpected_redirect");
        end
    end

    task automatic expect_rec(input logic [3:0] emask, input logic [31:0] epc, input logic ack);
        exp_t e;
        exp_cnt = ack ? 4'd1 : ((exp_cnt == 4'hF) ? exp_cnt : exp_cnt + 4'd1);
        e.mask = emask;
        e.pc   = epc;
        e.cnt  = exp_cnt;
        e.slow = (exp_cnt >= 4'(c_THRESH));
        exp_q.push_back(e);
    endtask

    task automatic recover(input logic [3:0] err, input logic [127:0] pcs, input logic ack,
                           input logic [3:0] emask, input logic [31:0] epc);
        expect_rec(emask, epc, ack);
        @(posedge clk); #1;
        bus.stage_err = err;
        bus.stage_pc  = pcs;
        bus.slow_ack  = ack;
        @(posedge clk); #1;
        bus.stage_err = '0;
        bus.slow_ack  = 1'b0;
        repeat (c_REPLAY + 3) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        bus.stage_err = '0;
        bus.stage_pc  = '0;
        bus.slow_ack  = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_stall", bus.stall, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_razor_reset", bus.razor_reset, 0);
        check("rst_redirect_valid", bus.redirect_valid, 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        check("rst_recovering", bus.recovering, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_slow_req", bus.slow_req, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Youngest stage error, then two simultaneous errors (oldest wins)
        recover(4'b0001, pcs4(32'h0, 32'h0, 32'h0, 32'h40), 1'b0, 4'b0001, 32'h40);
        recover(4'b0110, pcs4(32'h0, 32'h100, 32'h104, 32'h0), 1'b0, 4'b0111, 32'h100);

        // MEM/WB error; a further pulse during REPLAY must be ignored
        expect_rec(4'b1111, 32'h200, 1'b0);
        @(posedge clk); #1;
        bus.stage_err = 4'b1000;
        bus.stage_pc  = pcs4(32'h200, 32'h204, 32'h208, 32'h20C);
        @(posedge clk); #1;
        bus.stage_err = '0;
        @(posedge clk); #1;
        bus.stage_err = 4'b0100;
        @(posedge clk); #1;
        bus.stage_err = '0;
        repeat (c_REPLAY + 3) @(posedge clk);

        // Error held through a whole recovery re-triggers at minimum spacing
        expect_rec(4'b0011, 32'h80, 1'b0);
        expect_rec(4'b0011, 32'h80, 1'b0);
        @(posedge clk); #1;
        bus.stage_err = 4'b0010;
        bus.stage_pc  = pcs4(32'h0, 32'h0, 32'h80, 32'h0);
        repeat (c_REPLAY + 4) @(posedge clk); #1;
        bus.stage_err = '0;
        repeat (c_REPLAY + 3) @(posedge clk); #1;
        check("recovery_spacing", last_flush_cyc - prev_flush_cyc, c_REPLAY + 3);

        // Events 6..8 reach the slow-down threshold
        for (int i = 0; i < 3; i++)
            recover(4'b0100, pcs4(32'h0, 32'h300 + 32'(i * 4), 32'h0, 32'h0), 1'b0, 4'b0111,
                    32'h300 + 32'(i * 4));
        #1;
        check("thresh_count", bus.err_count, 8);
        check("thresh_slow_req", bus.slow_req, 1);

        // slow_ack alone clears the count
        @(posedge clk); #1;
        bus.slow_ack = 1'b1;
        @(posedge clk); #1;
        bus.slow_ack = 1'b0;
        exp_cnt = 4'd0;
        check("ack_count", bus.err_count, 0);
        check("ack_slow_req", bus.slow_req, 0);

        // slow_ack with a new error leaves count at one
        recover(4'b1000, pcs4(32'h400, 32'h0, 32'h0, 32'h0), 1'b1, 4'b1111, 32'h400);
        #1;
        check("ack_inc_count", bus.err_count, 1);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++)
            recover(4'b0001, pcs4(32'h0, 32'h0, 32'h0, 32'h1000 + 32'(i * 16)), 1'b0, 4'b0001,
                    32'h1000 + 32'(i * 16));
        #1;
        check("sat_count", bus.err_count, 15);
        check("sat_slow_req", bus.slow_req, 1);

        // Reset asserted in REPLAY aborts the recovery
        expect_rec(4'b0001, 32'h500, 1'b0);
        @(posedge clk); #1;
        bus.stage_err = 4'b0001;
        bus.stage_pc  = pcs4(32'h0, 32'h0, 32'h0, 32'h500);
        @(posedge clk); #1;
        bus.stage_err = '0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("rstmid_stall", bus.stall, 0);
        check("rstmid_flush", bus.flush, 0);
        check("rstmid_recovering", bus.recovering, 0);
        check("rstmid_razor_reset", bus.razor_reset, 0);
        check("rstmid_err_count", bus.err_count, 0);
        exp_cnt = 4'd0;
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("post_rst_count", bus.err_count, 0);
        check("post_rst_slow_req", bus.slow_req, 0);

        check("pending_expected", exp_q.size(), 0);
        check("recovery_open", active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
